viterbi_traceback: RTL and testbench
====================================

# viterbi_traceback

Survivor-memory and traceback controller for the 4-state (K=3) Viterbi decoder. It sits between the add-compare-select stage and the decoded-bit sink. It buffers one block of per-stage survivor flag vectors, then traces back from the winning end node one stage per cycle, and emits the decoded bits in forward (stage 0 first) order over a valid/ready interface.

## Interface
- DEPTH, 16: maximum stages per block; must be a power of two, at least 2.
- AW, 4: address width, equal to log2(DEPTH).

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  survivor vector present this cycle.
- in_ready  out  1  block can accept a survivor vector.
- surv  in  8  survivor flags; bits [2n+1:2n] are the 2-bit flag of node n (n = 0..3).
- in_last  in  1  qualifies the final stage of the block.
- best_node  in  2  traceback start node; sampled only on the beat that ends the block.
- out_valid  out  1  decoded bit valid.
- out_ready  in  1  sink accepts the decoded bit.
- out_data  out  1  decoded bit.
- out_last  out  1  marks the last decoded bit of the block.
- busy  out  1  high in TRACE and EMIT.
- done  out  1  one-cycle pulse after the last bit is accepted.

## Operation
- FSM states: FILL → TRACE → EMIT → FILL.
- **FILL**
  - in_ready = 1.
  - An accepted beat (in_valid & in_ready) writes surv into mem[wr_ptr] and increments wr_ptr.
  - The beat ends the block if in_last = 1, or if wr_ptr = DEPTH-1 (forced last).
  - On the ending beat: N = wr_ptr + 1, node ← best_node, rd_ptr ← wr_ptr, go to TRACE.
- **TRACE**
  - in_ready = 0; in_valid is ignored.
  - Each cycle: f = mem[rd_ptr][2·node+1 : 2·node]; apply the step rule; bitbuf[rd_ptr] ← d; node ← next.
  - When rd_ptr = 0, go to EMIT with emit_ptr = 0. Otherwise decrement rd_ptr.
  - TRACE therefore lasts exactly N cycles.
- **Step rule** (node, f → d, next):
  - node 00: f=10 → 0, 00; f=01 → 0, 01; any other f → 1, 11.
  - node 01: f=10 → 0, 10; f=01 → 0, 11; any other f → 0, 00.
  - node 10: f=10 → 1, 00; any other f → 1, 01.
  - node 11: f=10 → 1, 10; f=01 → 1, 11; any other f → 0, 00.
- **EMIT**
  - out_valid = 1, out_data = bitbuf[emit_ptr], out_last = (emit_ptr = N-1).
  - Each handshake increments emit_ptr.
  - The handshake with out_last = 1 moves the FSM to FILL, clears wr_ptr and pulses done in the next cycle.
- Pointer arithmetic is AW-bit unsigned. wr_ptr never wraps, because the forced last fires at DEPTH-1.

## Timing
- Reset (rst = 0 at a clock edge):
  - state FILL; wr_ptr, rd_ptr and emit_ptr = 0; node = 00.
  - in_ready = 1; out_valid, out_data, out_last, busy and done = 0.
  - bitbuf and mem are not cleared.
- Reset asserted mid-TRACE or mid-EMIT aborts the block. No done pulse is generated, and no further out_valid appears.
- Latency:
  - Ending beat accepted at edge t → TRACE during cycles t+1 … t+N.
  - out_valid is first high in cycle t+N+1.
  - With out_ready held high, one bit is emitted per cycle.
- in_ready drops in the cycle after the ending beat and returns high in the same cycle as done.
- The first beat of the next block may be accepted in that done cycle.
- While out_valid & !out_ready: out_data and out_last hold stable, and out_valid stays high.
- Outputs are registered or decoded from state and pointers only. There is no combinational path from out_ready or in_valid to any output.

## Test plan
- **Reset:** drive rst = 0 for 2 cycles with random inputs → in_ready = 1; out_valid, busy and done = 0. Repeat with rst = 0 in mid-TRACE → out_valid never rises and in_ready = 1 after release.
- **All-zero path:** 4 beats of surv = 8'hAA, in_last on beat 4, best_node = 00 → after 4 TRACE cycles, emits 0,0,0,0 with out_last on the 4th bit, then a single done pulse.
- **Known path:** surv = 8'h04, 8'h01, 8'h20 (in_last on the 3rd), best_node = 10 → trace visits nodes 10→00→01; output order is 0,0,1.
- **Non-one-hot flags:**
  - surv = 8'h00, best_node = 00, N = 1 → output 1.
  - surv = 8'h0C, best_node = 01, N = 1 → output 0.
- **Backpressure:** N = 5 with out_ready toggling every cycle → out_data and out_last stay stable while stalled; exactly 5 handshakes; done one cycle after the last handshake.
- **Overflow:** 16 beats without in_last, plus in_valid held high during TRACE → block ends at beat 16; extra beats are not accepted (in_ready = 0); 16 bits are output with out_last on the 16th.

Source files
------------

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: survivor memory + traceback for a 4-state (K=3) Viterbi decoder
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready/surv[7:0]/in_last/best_node[1:0] : survivor vectors from ACS, one per stage
//   out_valid/out_ready/out_data/out_last             : decoded bits, stage 0 first
//   busy (TRACE or EMIT), done (pulse after last bit accepted)
module viterbi_traceback #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] surv,
  input  logic       in_last,
  input  logic [1:0] best_node,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_data,
  output logic       out_last,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {FILL, TRACE, EMIT} state_t;
  state_t state, state_nx;
  logic [AW-1:0] wr_ptr, rd_ptr, emit_ptr, last_ptr;
  logic [1:0] node, f, nxt;
  logic [7:0] mem [DEPTH];
  logic [7:0] row;
  logic [DEPTH-1:0] bitbuf;
  logic d, accept, end_beat, hs;
  assign accept = state == FILL && in_valid;
  // forced last at DEPTH-1 keeps wr_ptr from wrapping into a live block
  assign end_beat = in_last || wr_ptr == AW'(DEPTH - 1);
  assign hs = state == EMIT && out_ready;
  assign in_ready = state == FILL;
  assign out_valid = state == EMIT;
  assign busy = state != FILL;
  assign out_data = out_valid && bitbuf[emit_ptr];
  assign out_last = out_valid && emit_ptr == last_ptr;
  assign row = mem[rd_ptr];
  assign f = row[{node, 1'b0} +: 2];
  always_comb begin
    {d, nxt} = 3'b000;
    case (node)
      2'b00:   {d, nxt} = f == 2'b10 ? 3'b000 : f == 2'b01 ? 3'b001 : 3'b111;
      2'b01:   {d, nxt} = f == 2'b10 ? 3'b010 : f == 2'b01 ? 3'b011 : 3'b000;
      2'b10:   {d, nxt} = f == 2'b10 ? 3'b100 : 3'b101;
      default: {d, nxt} = f == 2'b10 ? 3'b110 : f == 2'b01 ? 3'b111 : 3'b000;
    endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      FILL:    state_nx = accept && end_beat ? TRACE : FILL;
      TRACE:   state_nx = rd_ptr == '0 ? EMIT : TRACE;
      EMIT:    state_nx = hs && out_last ? FILL : EMIT;
      default: state_nx = FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      emit_ptr <= '0;
      last_ptr <= '0;
      node <= 2'b00;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= hs && out_last;
      case (state)
        FILL: if (accept) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (end_beat) begin
            last_ptr <= wr_ptr;
            rd_ptr <= wr_ptr;
            node <= best_node;
          end
        end
        TRACE: begin
          node <= nxt;
          if (rd_ptr == '0) emit_ptr <= '0;
          else rd_ptr <= rd_ptr - AW'(1);
        end
        EMIT: if (hs) begin
          emit_ptr <= emit_ptr + AW'(1);
          if (out_last) wr_ptr <= '0;
        end
        default: ;
      endcase
    end
  end
  // storage is intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (rst && accept) mem[wr_ptr] <= surv;
    if (rst && state == TRACE) bitbuf[rd_ptr] <= d;
  end
endmodule

// File: tb/tb_viterbi_traceback.sv
// tb_viterbi_traceback: scoreboard bench for viterbi_traceback
module tb_viterbi_traceback;
  logic clk = 0, rst = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid, out_data, out_last, busy, done;
  logic [7:0] surv = 0;
  logic [1:0] best_node = 0;
  int errors = 0, checks = 0;
  logic [1:0] exp_q[$];
  logic [7:0] blk[$];

  always #5 clk = ~clk;

  viterbi_traceback #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .surv(surv),
    .in_last(in_last), .best_node(best_node), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  function automatic logic [2:0] model_step(input logic [1:0] nd, input logic [1:0] f);
    if (f == 2'b10) return {nd[1], nd[0], 1'b0};
    if (f == 2'b01 || nd == 2'b10) return {nd[1], nd[0], 1'b1};
    return nd == 2'b00 ? 3'b111 : 3'b000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [1:0] best, input bit use_last, input bit hold);
    int n = blk.size();
    logic [1:0] nd = best;
    logic bits[16];
    int w;
    for (int i = n - 1; i >= 0; i--) begin
      logic [7:0] v = blk[i];
      logic [2:0] r = model_step(nd, v[2*nd +: 2]);
      bits[i] = r[2];
      nd = r[1:0];
    end
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, bits[i]});
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      surv = blk[i];
      in_last = use_last && i == n - 1;
      best_node = i == n - 1 ? best : 2'($urandom);
      w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      checks++;
      if (!in_ready) begin errors++; $display("FAIL feed_ready: beat %0d in_ready=%b expected 1", i, in_ready); end
      tick();
      in_valid = hold;
      in_last = 0;
      surv = 8'($urandom);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL after_end: in_ready=%b busy=%b expected 0 1", in_ready, busy);
    end
  endtask

  task automatic drain(input int mode, input int n);
    int cyc = 0, hsn = 0;
    bit stalled = 0, fin = 0;
    logic pd = 0, pl = 0;
    logic [1:0] e;
    while (!out_valid && cyc < 100) begin
      checks++;
      if (done !== 1'b0 || (in_valid && in_ready !== 1'b0)) begin
        errors++;
        $display("FAIL trace_phase: done=%b in_ready=%b expected 0 0", done, in_ready);
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc != n) begin errors++; $display("FAIL latency: got %0d cycles expected %0d", cyc, n); end
    cyc = 0;
    while (!fin && cyc < 200) begin
      out_ready = mode == 0 || cyc[0];
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid: got %b expected 1", out_valid);
        fin = 1;
      end else begin
        if (stalled) begin
          checks++;
          if (out_data !== pd || out_last !== pl) begin
            errors++;
            $display("FAIL stall_hold: data/last=%b%b expected %b%b", out_data, out_last, pd, pl);
          end
        end
        if (in_valid) begin
          checks++;
          if (in_ready !== 1'b0) begin errors++; $display("FAIL emit_in_ready: got %b expected 0", in_ready); end
        end
        if (out_ready) begin
          hsn++;
          e = exp_q.size() ? exp_q.pop_front() : 2'bxx;
          checks++;
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL bit%0d: last,data=%b%b expected %b", hsn - 1, out_last, out_data, e);
          end
          if (out_last) begin
            in_valid = 0;
            tick();
            out_ready = 0;
            checks++;
            if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
              errors++;
              $display("FAIL done_cycle: done=%b in_ready=%b out_valid=%b busy=%b expected 1 1 0 0",
                       done, in_ready, out_valid, busy);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
            fin = 1;
          end
        end
        stalled = !out_ready;
        pd = out_data;
        pl = out_last;
      end
      if (!fin) begin tick(); cyc++; end
    end
    out_ready = 0;
    in_valid = 0;
    checks++;
    if (hsn != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL handshakes: got %0d left %0d expected %0d left 0", hsn, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom); surv = 8'($urandom); in_last = 1'($urandom);
      best_node = 2'($urandom); out_ready = 1'($urandom);
      tick();
    end
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0 || done !== 0 || out_last !== 0 || out_data !== 0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b done=%b expected 1 0 0 0",
               in_ready, out_valid, busy, done);
    end
    in_valid = 0; in_last = 0; out_ready = 0;
    rst = 1;
    tick();
  endtask

  task automatic test_all_zero();
    blk = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
    feed(2'b00, 1, 0);
    drain(0, 4);
  endtask

  task automatic test_known_path();
    blk = '{8'h04, 8'h01, 8'h20};
    feed(2'b10, 1, 0);
    drain(0, 3);
  endtask

  task automatic test_non_one_hot();
    blk = '{8'h00};
    feed(2'b00, 1, 0);
    drain(0, 1);
    blk = '{8'h0C};
    feed(2'b01, 1, 0);
    drain(0, 1);
  endtask

  task automatic test_backpressure();
    blk.delete();
    for (int i = 0; i < 5; i++) blk.push_back(8'($urandom));
    feed(2'($urandom), 1, 0);
    drain(1, 5);
  endtask

  task automatic test_overflow();
    blk.delete();
    for (int i = 0; i < 16; i++) blk.push_back(8'($urandom));
    feed(2'($urandom), 0, 1);
    drain(0, 16);
  endtask

  task automatic test_reset_mid_trace();
    blk.delete();
    for (int i = 0; i < 8; i++) blk.push_back(8'($urandom));
    feed(2'($urandom), 1, 0);
    tick();
    tick();
    rst = 0;
    tick();
    rst = 1;
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (out_valid !== 0 || done !== 0 || in_ready !== 1) begin
        errors++;
        $display("FAIL abort: out_valid=%b done=%b in_ready=%b expected 0 0 1", out_valid, done, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      blk.delete();
      for (int i = 0; i < 2 + k * 3; i++) blk.push_back(8'($urandom));
      feed(2'($urandom), 1, 0);
      drain(k == 1, 2 + k * 3);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_known_path();
    test_non_one_hot();
    test_backpressure();
    test_overflow();
    test_reset_mid_trace();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
